// File: rtl/rpn_pkg.sv
// Shared RPN executor definitions: opcodes, FSM states, flag bit positions.
// Used by the executor datapath and the downstream display/decoder stage.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // flags_out layout: {err, ovf, carry, neg, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ERR   = 4;
  localparam int FLAG_W     = 5;

  localparam int MD_STEPS = 8;

  function automatic logic is_mul_div(input opcode_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/d_flipflop.sv
// Single D flop with asynchronous active-low clear; building block for synchronisers.
// Latency 1 clk; no backpressure.
module d_flipflop (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 8-step shift-add multiplier / restoring divider; step 1 runs on the start edge.
// done is high in the cycle after the 8th step; start is only issued while idle, no backpressure.
module mul_div_unit import rpn_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       hi_nonzero,
  output logic       div_zero,
  output logic       done
);

  // MUL: acc=partial product, x=shifted multiplicand, y=remaining multiplier bits.
  // DIV: acc[8:0]=partial remainder, x[7:0]=dividend shifting into quotient, y=divisor.
  logic [15:0] acc_q, acc_cur, acc_nxt;
  logic [15:0] x_q, x_cur, x_nxt;
  logic [7:0]  y_q, y_cur, y_nxt;
  logic        op_q, op_cur, active_q;
  logic [3:0]  cnt_q;
  logic [8:0]  rem_shift, rem_sub;
  logic        rem_ge;

  always_comb begin
    acc_cur   = start ? 16'd0 : acc_q;
    x_cur     = start ? {8'd0, a} : x_q;
    y_cur     = start ? b : y_q;
    op_cur    = start ? op : op_q;
    rem_shift = {acc_cur[7:0], x_cur[7]};
    rem_ge    = rem_shift >= {1'b0, y_cur};
    rem_sub   = rem_shift - {1'b0, y_cur};
    if (op_cur) begin
      acc_nxt = {7'd0, rem_ge ? rem_sub : rem_shift};
      x_nxt   = {8'd0, x_cur[6:0], rem_ge};
      y_nxt   = y_cur;
    end else begin
      acc_nxt = acc_cur + (y_cur[0] ? x_cur : 16'd0);
      x_nxt   = {x_cur[14:0], 1'b0};
      y_nxt   = {1'b0, y_cur[7:1]};
    end
  end

  assign done = active_q && (cnt_q == 4'(MD_STEPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (start || (active_q && !done)) begin
        acc_q <= acc_nxt;
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        op_q  <= op_cur;
      end
      if (start) begin
        active_q <= 1'b1;
        cnt_q    <= 4'd1;
      end else if (done) begin
        active_q <= 1'b0;
      end else if (active_q) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // Divide by zero falls out of restoring division as an all-ones quotient.
  assign result     = op_q ? x_q[7:0] : acc_q[7:0];
  assign hi_nonzero = |acc_q[15:8];
  assign div_zero   = (y_q == 8'd0);

endmodule

// File: rtl/rpn_executor.sv
// RPN ALU: synchronised execute edge captures A/B/op; 1-cycle logic/add/sub, 8-cycle mul/div.
// Starts arriving while busy are dropped, never queued; no backpressure to the shift register.
module rpn_executor import rpn_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                execute_in,
  input  logic [7:0]          opcode_in,
  input  logic [7:0]          operand_b_in,
  input  logic [7:0]          operand_a_in,
  output logic [7:0]          result_out,
  output logic [FLAG_W-1:0]   flags_out,
  output logic                busy_out,
  output logic                done_out
);

  logic [SYNC_STAGES:0] sync_chain;
  logic prev_q, primed_q, armed_q, start;

  assign sync_chain[0] = execute_in;
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    d_flipflop u_ff (.clk(clk), .reset(reset), .d(sync_chain[i]), .q(sync_chain[i+1]));
  end

  // armed only after a genuine low has been sampled, so a level held across reset cannot start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      prev_q   <= sync_chain[SYNC_STAGES];
      primed_q <= 1'b1;
      armed_q  <= armed_q | (primed_q & ~sync_chain[1]);
    end
  end

  assign start = sync_chain[SYNC_STAGES] & ~prev_q & armed_q;

  state_e  state_q, state_nxt;
  opcode_e op_q;
  logic [7:0] a_q, b_q, result_q, alu_res, md_result;
  logic [FLAG_W-1:0] flags_q, alu_flags;
  logic capture, md_start, exec_exit, md_hi_nonzero, md_div_zero, md_done;
  logic alu_carry, alu_ovf, alu_err;
  logic [8:0] sum9, diff9;
  logic unused_opcode_bits;

  assign unused_opcode_bits = ^opcode_in[7:3];
  assign capture  = (state_q == ST_IDLE) && start;
  assign md_start = capture && is_mul_div(opcode_e'(opcode_in[2:0]));

  mul_div_unit u_mul_div (
    .clk        (clk),
    .reset      (reset),
    .start      (md_start),
    .op         (opcode_in[0]),
    .a          (operand_a_in),
    .b          (operand_b_in),
    .result     (md_result),
    .hi_nonzero (md_hi_nonzero),
    .div_zero   (md_div_zero),
    .done       (md_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    exec_exit = 1'b0;
    busy_out  = (state_q != ST_IDLE);
    done_out  = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: if (start) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!is_mul_div(op_q) || md_done) begin
          exec_exit = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sum9      = {1'b0, a_q} + {1'b0, b_q};
    diff9     = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = 8'd0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
        alu_ovf   = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
      end
      OP_SUB: begin
        alu_res   = diff9[7:0];
        alu_carry = diff9[8];
        alu_ovf   = (a_q[7] != b_q[7]) && (diff9[7] != a_q[7]);
      end
      OP_MUL: begin
        alu_res   = md_result;
        alu_carry = md_hi_nonzero;
      end
      OP_DIV: begin
        alu_res = md_result;
        alu_err = md_div_zero;
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = ~a_q;
    endcase
    alu_flags             = '0;
    alu_flags[FLAG_ZERO]  = (alu_res == 8'd0);
    alu_flags[FLAG_NEG]   = alu_res[7];
    alu_flags[FLAG_CARRY] = alu_carry;
    alu_flags[FLAG_OVF]   = alu_ovf;
    alu_flags[FLAG_ERR]   = alu_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (capture) begin
        a_q  <= operand_a_in;
        b_q  <= operand_b_in;
        op_q <= opcode_e'(opcode_in[2:0]);
      end
      if (exec_exit) begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end
    end
  end

  assign result_out = result_q;
  assign flags_out  = flags_q;

endmodule

// File: tb/tb_rpn_executor.sv
// Self-checking bench for rpn_executor: directed vector table, random ops vs. arithmetic model,
// plus hand sequences for retrigger-while-busy and reset-mid-divide.
module tb_rpn_executor;

  logic       clk = 1'b0;
  logic       reset;
  logic       execute_in;
  logic [7:0] opcode_in, operand_b_in, operand_a_in;
  logic [7:0] result_out;
  logic [4:0] flags_out;
  logic       busy_out, done_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rpn_executor #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .execute_in   (execute_in),
    .opcode_in    (opcode_in),
    .operand_b_in (operand_b_in),
    .operand_a_in (operand_a_in),
    .result_out   (result_out),
    .flags_out    (flags_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] fl;
    int         lat;
    int         busy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: {err, ovf, carry, neg, zero, result} from plain integer arithmetic.
  function automatic logic [12:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, sa, sb, r;
    logic c, o, e;
    logic [7:0] r8;
    ia = int'(a); ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    c = 1'b0; o = 1'b0; e = 1'b0; r = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); o = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = ia - ib; c = (ia < ib); o = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: begin r = ia * ib; c = (r > 255); end
      3'd3: begin if (ib == 0) begin r = 255; e = 1'b1; end else r = ia / ib; end
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: r = 255 - ia;
    endcase
    r8 = r[7:0];
    return {e, o, c, r8[7], (r8 == 8'd0), r8};
  endfunction

  // Raise execute with operands, observe 30 cycles; lat = negedge index (1 = after first
  // sampling edge) at which done_out is first seen, -1 if never.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [4:0] fl,
                        output int lat, output int busy_n, output int dones);
    @(negedge clk);
    opcode_in    = {5'($urandom), op};
    operand_a_in = a;
    operand_b_in = b;
    execute_in   = 1'b1;
    lat = -1; busy_n = 0; dones = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy_out) busy_n++;
      if (done_out) begin
        dones++;
        if (lat < 0) lat = n;
      end
      if (n == 3) begin
        operand_a_in = 8'($urandom);
        operand_b_in = 8'($urandom);
        opcode_in    = 8'($urandom);
      end
    end
    res = result_out;
    fl  = flags_out;
    execute_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0]  res;
    logic [4:0]  fl;
    logic [12:0] m;
    logic [2:0]  op;
    logic [7:0]  a, b;
    int lat, busy_n, dones;

    // start after sampling edge 2, capture at 3, result at 4 (+7 for mul/div)
    vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 5'b01010, 4, 2};
    vecs[1]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 5'b00110, 4, 2};
    vecs[2]  = '{3'd1, 8'h07, 8'h07, 8'h00, 5'b00001, 4, 2};
    vecs[3]  = '{3'd2, 8'h10, 8'h11, 8'h10, 5'b00100, 11, 9};
    vecs[4]  = '{3'd3, 8'd200, 8'd7, 8'h1C, 5'b00000, 11, 9};
    vecs[5]  = '{3'd3, 8'h33, 8'h00, 8'hFF, 5'b10010, 11, 9};
    vecs[6]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 5'b00000, 4, 2};
    vecs[7]  = '{3'd5, 8'h80, 8'h01, 8'h81, 5'b00010, 4, 2};
    vecs[8]  = '{3'd6, 8'hAA, 8'hAA, 8'h00, 5'b00001, 4, 2};
    vecs[9]  = '{3'd7, 8'h0F, 8'h55, 8'hF0, 5'b00010, 4, 2};
    vecs[10] = '{3'd0, 8'hFF, 8'h01, 8'h00, 5'b00101, 4, 2};
    vecs[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 5'b01000, 4, 2};
    vecs[12] = '{3'd2, 8'hFF, 8'hFF, 8'h01, 5'b00100, 11, 9};

    reset = 1'b0; execute_in = 1'b0;
    opcode_in = 8'h00; operand_a_in = 8'h00; operand_b_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(result_out), 32'h0);
    chk("reset_flags", 32'(flags_out), 32'h0);
    chk("reset_busy", 32'(busy_out), 32'h0);
    chk("reset_done", 32'(done_out), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, lat, busy_n, dones);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_done_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_done_pulses", i), 32'(dones), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      m  = model(op, a, b);
      run_op(op, a, b, res, fl, lat, busy_n, dones);
      chk($sformatf("rnd%0d_op%0d_result", i, op), 32'(res), 32'(m[7:0]));
      chk($sformatf("rnd%0d_op%0d_flags", i, op), 32'(fl), 32'(m[12:8]));
      chk($sformatf("rnd%0d_done_latency", i), 32'(lat), (op == 3'd2 || op == 3'd3) ? 32'd11 : 32'd4);
      chk($sformatf("rnd%0d_done_pulses", i), 32'(dones), 32'd1);
    end

    // Second execute edge while a MUL is in EXEC must be dropped.
    @(negedge clk);
    opcode_in = 8'h02; operand_a_in = 8'h10; operand_b_in = 8'h11; execute_in = 1'b1;
    dones = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done_out) dones++;
      if (n == 4) execute_in = 1'b0;
      if (n == 6) begin
        opcode_in = 8'h00; operand_a_in = 8'h01; operand_b_in = 8'h01; execute_in = 1'b1;
      end
    end
    chk("retrigger_done_pulses", 32'(dones), 32'd1);
    chk("retrigger_result", 32'(result_out), 32'h10);
    chk("retrigger_flags", 32'(flags_out), 32'h04);
    execute_in = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in EXEC cycle 4 of a DIV, execute_in held high across release.
    opcode_in = 8'h03; operand_a_in = 8'd200; operand_b_in = 8'd7; execute_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("middiv_busy_before_reset", 32'(busy_out), 32'h1);
    reset = 1'b0;
    #1;
    chk("middiv_reset_result", 32'(result_out), 32'h0);
    chk("middiv_reset_flags", 32'(flags_out), 32'h0);
    chk("middiv_reset_busy", 32'(busy_out), 32'h0);
    chk("middiv_reset_done", 32'(done_out), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0; busy_n = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done_out) dones++;
      if (busy_out) busy_n++;
    end
    chk("held_high_no_done", 32'(dones), 32'd0);
    chk("held_high_no_busy", 32'(busy_n), 32'd0);
    chk("held_high_result", 32'(result_out), 32'h0);
    execute_in = 1'b0;
    repeat (3) @(negedge clk);
    run_op(3'd0, 8'h01, 8'h02, res, fl, lat, busy_n, dones);
    chk("post_reset_result", 32'(res), 32'h03);
    chk("post_reset_latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_executor.md
RPN_EXECUTOR -- requirements
Module: rpn_executor

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, default 2, number of synchroniser flops on execute_in (minimum 2).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: execute_in  input  1  execute pulse from the operand shift register; asynchronous to clk.
REQ-006 SHALL have port: opcode_in  input  8  newest stack entry (reg1); bits [2:0] are used.
REQ-007 SHALL have port: operand_b_in  input  8  middle stack entry (reg2).
REQ-008 SHALL have port: operand_a_in  input  8  oldest stack entry (reg3).
REQ-009 SHALL have port: result_out  output  8  last completed result.
REQ-010 SHALL have port: flags_out  output  5  {err, ovf, carry, neg, zero}, registered with result_out.
REQ-011 SHALL have port: busy_out  output  1  high in EXEC and DONE.
REQ-012 SHALL have port: done_out  output  1  one-clk pulse when result_out/flags_out update.

Function
REQ-013 SHALL synchronise execute_in through SYNC_STAGES flops, then detect its rising edge as a one-cycle start.
REQ-014 With default SYNC_STAGES, start SHALL be asserted in the cycle after the 2nd sampling edge at which execute_in is high.
REQ-015 FSM SHALL have states IDLE, EXEC, DONE.
REQ-016 IDLE + start SHALL capture A, B and opcode[2:0] into internal registers and go to EXEC.
REQ-017 EXEC SHALL last 1 cycle for ADD(000), SUB(001), AND(100), OR(101), XOR(110) and NOT A(111).
REQ-018 EXEC SHALL last exactly 8 cycles for MUL(010) and DIV(011), using an iterative unit.
REQ-019 At EXEC exit, result and flags SHALL be registered in the same edge and the FSM SHALL go to DONE; done_out SHALL be high for exactly that one DONE cycle.
REQ-020 DONE SHALL return to IDLE unconditionally.
REQ-021 A start in EXEC or DONE SHALL be ignored: no queueing, no effect on the operation in progress.
REQ-022 Arithmetic SHALL be 8-bit unsigned, except that ovf SHALL be the two's-complement signed overflow for ADD/SUB.
REQ-023 ADD: carry SHALL be bit 8 of the sum.
REQ-024 SUB: result SHALL be A-B; carry SHALL be the borrow (1 when A<B).
REQ-025 MUL: result SHALL be the low byte of A*B; carry SHALL be 1 if the high byte is nonzero; ovf SHALL be 0.
REQ-026 DIV: result SHALL be floor(A/B), computed by restoring division; carry SHALL be 0 and ovf SHALL be 0.
REQ-027 DIV with B=0: result SHALL be 0xFF, err SHALL be 1, and the operation SHALL still take 8 EXEC cycles.
REQ-028 Logic ops and NOT: carry=0, ovf=0.
REQ-029 For all ops: zero=(result==0), neg=result[7]; err SHALL be 0 except for DIV by zero.
REQ-030 result_out/flags_out SHALL hold their values until the next DONE; inputs SHALL be ignored after capture.

Reset
REQ-031 Reset assertion SHALL immediately force: FSM=IDLE, result_out=0x00, flags_out=0, busy_out=0, done_out=0, synchroniser and edge-detect flops=0, iterative-unit registers=0.
REQ-032 Reset asserted mid-EXEC SHALL abort the operation; no done_out SHALL follow.
REQ-033 After reset release, a level already high on execute_in SHALL NOT generate a start; only a new rising edge SHALL.

Structure
REQ-034 Opcode constants, state encodings and flag bit positions SHALL live in shared package rpn_pkg, reused by the display/decoder stage.
REQ-035 The 8-cycle shift-add multiplier / restoring divider SHALL be one sub-module, mul_div_unit, with ports start, op, a, b, result, hi_nonzero, div_zero and done.
REQ-036 The synchroniser SHALL reuse the team d_flipflop cell.

Verification
REQ-037 A=0x7F, B=0x01, ADD -> result 0x80, flags ovf=1 neg=1 carry=0 zero=0; done_out 4 edges after the first sampling edge of execute_in high.
REQ-038 A=0x05, B=0x07, SUB -> 0xFE, carry=1, neg=1; A=0x07, B=0x07, SUB -> 0x00, zero=1.
REQ-039 A=0x10, B=0x11, MUL -> 0x10, carry=1, busy_out high 9 cycles; A=200, B=7, DIV -> 0x1C; A=0x33, B=0x00, DIV -> 0xFF, err=1.
REQ-040 Second execute_in edge during a MUL -> ignored, exactly one done_out, result of the first operation only.
REQ-041 Reset asserted in EXEC cycle 4 of a DIV -> outputs 0 immediately, no done_out; held-high execute_in after release -> no start.
